// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges a single-cycle ALU result stream (source A, strict priority)
// with a FIFO-buffered multi-cycle unit stream (source B) into one registered
// register-file write port.
// Optional feature: define WB_PENDING_EN to build the scoreboard query (q_pending).
module writeback_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  input  logic [4:0]               a_rd,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_rd,
  input  logic [31:0]              b_data,
  output logic                     WE,
  output logic [4:0]               A3,
  output logic [31:0]              WD3,
  output logic [$clog2(DEPTH):0]   fifo_count,
  input  logic [4:0]               q_rs,
  output logic                     q_pending
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [4:0]      rd_mem_q   [DEPTH];
  logic [31:0]     data_mem_q [DEPTH];

  logic        we_q, we_d;
  logic [4:0]  a3_q, a3_d;
  logic [31:0] wd3_q, wd3_d;

  logic push, pop;

  // Ready only while not full; a same-cycle pop does not free a slot for the push.
  assign b_ready = ~rst & (count_q < CntW'(DEPTH));
  assign push    = b_valid & b_ready;
  // A owns the slot whenever it is valid; B only drains on idle A cycles.
  assign pop     = ~a_valid & (count_q != '0);

  // Select the writer for the next slot and update FIFO bookkeeping.
  always_comb begin
    we_d     = 1'b0;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (a_valid) begin
      a3_d  = a_rd;
      wd3_d = a_data;
      we_d  = !((ZERO_REG != 0) && (a_rd == 5'd0));
    end else if (pop) begin
      a3_d  = rd_mem_q[rd_ptr_q];
      wd3_d = data_mem_q[rd_ptr_q];
      we_d  = !((ZERO_REG != 0) && (rd_mem_q[rd_ptr_q] == 5'd0));
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO and cancels any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      we_q     <= we_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; entry validity comes from the pointers and count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= b_rd;
      data_mem_q[wr_ptr_q] <= b_data;
    end
  end

  assign WE         = we_q;
  assign A3         = a3_q;
  assign WD3        = wd3_q;
  assign fifo_count = count_q;

`ifdef WB_PENDING_EN
  logic            pend;
  logic [PtrW-1:0] offs;

  // Pending if q_rs is targeted by a queued entry, the issuing write or the incoming A result.
  always_comb begin
    pend = 1'b0;
    offs = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PtrW'(i) - rd_ptr_q;
      if ((CntW'(offs) < count_q) && (rd_mem_q[i] == q_rs)) pend = 1'b1;
    end
    if (we_q && (a3_q == q_rs))     pend = 1'b1;
    if (a_valid && (a_rd == q_rs))  pend = 1'b1;
    if ((ZERO_REG != 0) && (q_rs == 5'd0)) pend = 1'b0;
    if (rst) pend = 1'b0;
  end

  assign q_pending = pend;
`else
  logic unused_q_rs;
  assign unused_q_rs = ^q_rs;
  assign q_pending   = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter. Expected writes are queued in issue order by the
// stimulus; a negedge monitor pops and compares each write the DUT presents.
module tb_writeback_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

`ifdef WB_PENDING_EN
  localparam bit PendEn = 1'b1;
`else
  localparam bit PendEn = 1'b0;
`endif

  logic        clk, rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd, q_rs;
  logic [31:0] a_data, b_data;

  logic        b_ready, we, q_pending;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [2:0]  fifo_count;

  logic        f_b_ready, f_we, f_q_pending;
  logic [4:0]  f_a3;
  logic [31:0] f_wd3;
  logic [2:0]  f_fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  writeback_arbiter #(.DEPTH(4), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .WE(we), .A3(a3), .WD3(wd3), .fifo_count(fifo_count),
    .q_rs(q_rs), .q_pending(q_pending)
  );

  // Float-file flavour, used only for the register-0 write case.
  writeback_arbiter #(.DEPTH(4), .ZERO_REG(0)) u_dut_f (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(f_b_ready), .b_rd(b_rd), .b_data(b_data),
    .WE(f_we), .A3(f_a3), .WD3(f_wd3), .fifo_count(f_fifo_count),
    .q_rs(q_rs), .q_pending(f_q_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every presented write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got A3=%0d WD3=0x%0h, expected no write", a3, wd3);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_a3", 32'(a3), 32'(mon_e.rd));
        chk("wb_wd3", wd3, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_rd = '0; b_rd = '0; q_rs = '0; a_data = '0; b_data = '0;

    // Reset state
    tick();
    mid();
    chk("rst_we", 32'(we), 0);
    chk("rst_a3", 32'(a3), 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_q_pending", 32'(q_pending), 0);
    tick();
    rst = 1'b0;
    tick();

    // Single A write, then hold of A3/WD3 on an idle slot
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    tick();
    a_valid = 1'b0;
    tick();
    mid();
    chk("idle_we", 32'(we), 0);
    chk("idle_a3_hold", 32'(a3), 5);
    chk("idle_wd3_hold", wd3, 32'hDEADBEEF);
    tick();

    // B entry waits behind three A writes
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h101;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h11;
    expect_wr(5'd1, 32'h101);
    tick();
    b_valid = 1'b0;
    a_rd = 5'd2; a_data = 32'h102;
    expect_wr(5'd2, 32'h102);
    mid();
    chk("starve_count", 32'(fifo_count), 1);
    tick();
    a_rd = 5'd3; a_data = 32'h103;
    expect_wr(5'd3, 32'h103);
    tick();
    a_valid = 1'b0;
    expect_wr(5'd7, 32'h11);
    tick();
    mid();
    chk("drain_count", 32'(fifo_count), 0);
    tick();

    // Fill to DEPTH under A traffic, then drain in push order
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_rd = 5'(10 + i); a_data = 32'hA0 + 32'(i);
      b_valid = 1'b1; b_rd = 5'(20 + i); b_data = 32'hB0 + 32'(i);
      expect_wr(5'(10 + i), 32'hA0 + 32'(i));
      tick();
    end
    a_rd = 5'd14; a_data = 32'hA4;
    b_rd = 5'd24; b_data = 32'hB4;
    expect_wr(5'd14, 32'hA4);
    mid();
    chk("full_count", 32'(fifo_count), 4);
    chk("full_b_ready", 32'(b_ready), 0);
    tick();
    a_valid = 1'b0;
    expect_wr(5'd20, 32'hB0);
    mid();
    chk("full_pop_no_ready", 32'(b_ready), 0);
    tick();
    expect_wr(5'd21, 32'hB1);
    mid();
    chk("after_pop_b_ready", 32'(b_ready), 1);
    chk("after_pop_count", 32'(fifo_count), 3);
    tick();
    b_valid = 1'b0;
    expect_wr(5'd22, 32'hB2);
    mid();
    chk("push_pop_count", 32'(fifo_count), 3);
    tick();
    expect_wr(5'd23, 32'hB3);
    tick();
    expect_wr(5'd24, 32'hB4);
    tick();
    mid();
    chk("empty_count", 32'(fifo_count), 0);
    tick();
    mid();
    chk("empty_we", 32'(we), 0);
    tick();

    // Register-0 write: suppressed in the integer file, allowed in the float file
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h55;
    tick();
    a_valid = 1'b0;
    mid();
    chk("zr1_we", 32'(we), 0);
    chk("zr0_we", 32'(f_we), 1);
    chk("zr0_a3", 32'(f_a3), 0);
    chk("zr0_wd3", f_wd3, 32'h55);
    tick();

    // Pending query for a B entry queued behind A traffic
    q_rs = 5'd9;
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h201;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h909;
    expect_wr(5'd1, 32'h201);
    mid();
    chk("pend_c0", 32'(q_pending), 0);
    tick();
    b_valid = 1'b0;
    a_rd = 5'd2; a_data = 32'h202;
    expect_wr(5'd2, 32'h202);
    mid();
    chk("pend_queued", 32'(q_pending), 32'(PendEn));
    tick();
    a_valid = 1'b0;
    expect_wr(5'd9, 32'h909);
    mid();
    chk("pend_head", 32'(q_pending), 32'(PendEn));
    tick();
    mid();
    chk("pend_issuing", 32'(q_pending), 32'(PendEn));
    tick();
    mid();
    chk("pend_done", 32'(q_pending), 0);
    q_rs = 5'd0;
    tick();

    // Asynchronous reset with three queued entries and an A write in flight
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_rd = 5'(3 + i); a_data = 32'h300 + 32'(i);
      b_valid = 1'b1; b_rd = 5'(6 + i); b_data = 32'h600 + 32'(i);
      expect_wr(5'(3 + i), 32'h300 + 32'(i));
      tick();
    end
    a_rd = 5'd30; a_data = 32'h3030;
    b_valid = 1'b0;
    mid();
    chk("pre_rst_count", 32'(fifo_count), 3);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_we", 32'(we), 0);
    chk("async_rst_count", 32'(fifo_count), 0);
    chk("async_rst_b_ready", 32'(b_ready), 0);
    a_valid = 1'b0;
    tick();
    rst = 1'b0;
    mid();
    chk("post_rst_we", 32'(we), 0);
    tick();
    mid();
    chk("post_rst_we2", 32'(we), 0);
    chk("post_rst_count", 32'(fifo_count), 0);
    tick();
    tick();

    chk("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the source-B FIFO entry count (power of two, 2..16).
REQ-002 Parameter ZERO_REG, default 1, SHALL, when 1, suppress writes to register 0 (integer file); when 0, register 0 is writable (float file).
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning:
  clk         in   1   clock; all state updates on rising edge
  rst         in   1   asynchronous active-high reset
  a_valid     in   1   source A (single-cycle ALU) result valid; no backpressure
  a_rd        in   5   source A destination register
  a_data      in   32  source A result
  b_valid     in   1   source B (multi-cycle unit) result valid
  b_ready     out  1   source B FIFO can accept
  b_rd        in   5   source B destination register
  b_data      in   32  source B result
  WE          out  1   register-file write enable
  A3          out  5   register-file write address
  WD3         out  32  register-file write data
  fifo_count  out  $clog2(DEPTH)+1  valid entries in FIFO
  q_rs        in   5   scoreboard query register
  q_pending   out  1   q_rs has an outstanding write

Function
REQ-004 WE, A3 and WD3 SHALL be registered; exactly one write slot per cycle.
REQ-005 Source A SHALL have strict priority: a_valid in cycle n SHALL give WE=1, A3=a_rd, WD3=a_data in cycle n+1.
REQ-006 A B transfer SHALL occur when b_valid and b_ready are both 1 at a rising edge; the entry SHALL be pushed to the FIFO tail.
REQ-007 b_ready SHALL be (fifo_count < DEPTH) and rst low; no pass-through when full, even if a pop occurs in the same cycle.
REQ-008 When a_valid is 0 and fifo_count > 0, the FIFO head SHALL be popped and presented on WE/A3/WD3 the next cycle; minimum B latency is 2 cycles.
REQ-009 When neither a_valid nor a non-empty FIFO, WE SHALL be 0 next cycle; A3 and WD3 SHALL hold their previous values.
REQ-010 Simultaneous push and pop SHALL leave fifo_count unchanged; FIFO order SHALL be strict FIFO; pointers SHALL wrap modulo DEPTH.
REQ-011 With ZERO_REG=1, a selected entry with rd=0 SHALL consume its slot (popped or A-accepted) but SHALL drive WE=0.
REQ-012 Source A MAY starve source B indefinitely; no aging logic.

Reset
REQ-013 While rst is high: WE=0, A3=0, WD3=0, fifo_count=0, b_ready=0, q_pending=0, FIFO pointers=0; all FIFO entries invalidated.
REQ-014 Reset asserted mid-operation SHALL discard all queued and in-flight writes; no write SHALL issue in the first cycle after release.

Configuration
REQ-015 Macro WB_PENDING_EN SHALL compile in the scoreboard query logic.
REQ-016 With WB_PENDING_EN defined, q_pending SHALL be combinational: 1 if q_rs matches rd of any valid FIFO entry, or A3 while WE=1, or a_rd while a_valid=1; with ZERO_REG=1, q_rs=0 SHALL give 0.
REQ-017 Without WB_PENDING_EN, q_pending SHALL be tied to 0 and no comparator logic SHALL be instantiated.

Verification
REQ-018 a_valid=1, a_rd=5, a_data=0xDEADBEEF in cycle 0 -> WE=1, A3=5, WD3=0xDEADBEEF in cycle 1.
REQ-019 Push B rd=7 data=0x11 while a_valid held 1 for 3 cycles -> B write (A3=7, WD3=0x11) appears in the cycle after a_valid drops; A writes never lost.
REQ-020 Push 4 B entries with a_valid=1 constantly (DEPTH=4) -> fifo_count=4, b_ready=0; drop a_valid -> pops in push order, b_ready=1 after first pop.
REQ-021 ZERO_REG=1, a_valid=1, a_rd=0, a_data=0x55 -> next cycle WE=0; ZERO_REG=0 same stimulus -> WE=1, A3=0, WD3=0x55.
REQ-022 WB_PENDING_EN defined, B entry rd=9 queued behind A traffic, q_rs=9 -> q_pending=1 until the cycle after its write issues, then 0; undefined -> always 0.
REQ-023 Assert rst with fifo_count=3 -> WE=0, fifo_count=0 immediately (asynchronous); after release, no stale write issues.
